dpram_fifo_ctrl: RTL and testbench
==================================

Name: dpram_fifo_ctrl

Overview:
- Initiator-side controller for the 64x8 dual-port RAM: turns it into a synchronous FIFO with valid/ready streams on both sides.
- Port A is the write port. Port B is the read port, with its write enable tied low.
- Handles the RAM's one-cycle registered read latency with a 2-entry output buffer, so it sustains one push and one pop per cycle.
- Sits between a producer and a consumer; the RAM is instantiated alongside it in the parent, not inside it.

Parameters:
- DATA_W, 8, data width; matches the RAM word.
- ADDR_W, 6, RAM address width; RAM depth = 2**ADDR_W = 64.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller accepts data.
- in_data  in  DATA_W  write data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes data.
- out_data  out  DATA_W  head of FIFO.
- level  out  ADDR_W+2  total entries held (RAM + in-flight + output buffer), 0..DEPTH+2.
- ram_addr_a  out  ADDR_W  to RAM addr_a.
- ram_data_a  out  DATA_W  to RAM data_a.
- ram_wr_a  out  1  to RAM wr_a.
- ram_addr_b  out  ADDR_W  to RAM addr_b.
- ram_data_b  out  DATA_W  to RAM data_b; constant 0.
- ram_wr_b  out  1  to RAM wr_b; constant 0.
- ram_q_b  in  DATA_W  from RAM q_b.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_ptr, rd_ptr, ram_cnt, pending, buf_cnt all go to 0; out_valid=0; out_data=0; level=0.
  - RAM contents are not cleared; the FIFO is logically empty.
  - Reset mid-stream discards all data, including any in-flight read.
- Push:
  - push = in_valid & in_ready, where in_ready = (ram_cnt < DEPTH).
  - ram_wr_a = push, ram_addr_a = wr_ptr, ram_data_a = in_data; all combinational.
  - On push, wr_ptr increments and wraps modulo DEPTH (63 -> 0).
- Read issue:
  - pop = out_valid & out_ready.
  - rd_en = (ram_cnt > 0) & ((buf_cnt + pending - pop) < 2).
  - ram_addr_b = rd_ptr, combinational.
  - On rd_en: rd_ptr increments with wrap, and pending <= 1; otherwise pending <= 0.
- Capture: when pending=1, ram_q_b is written into the output buffer at that edge. This is the data read one cycle after issue.
- Output buffer:
  - 2-entry FIFO of registers.
  - out_data is entry 0, out_valid = (buf_cnt != 0).
  - On a simultaneous pop and capture with buf_cnt=1, the captured word becomes the new head.
- Counters:
  - ram_cnt <= ram_cnt + push - rd_en.
  - buf_cnt <= buf_cnt + pending - pop.
  - level = ram_cnt + pending + buf_cnt.
- Latency: a word pushed at edge N into an empty FIFO is issued at N+1, captured at N+2, and out_valid is high after edge N+2 (3-cycle fall-through).
- Full: in_ready=0 when ram_cnt=DEPTH; in_data is ignored. level can reach DEPTH+2.
- Empty: rd_en=0 when ram_cnt=0; out_valid stays high while buf_cnt>0.
- Read/write collision: a read is never issued to an address whose write occurs in the same cycle, because ram_cnt only counts completed writes.
- Simultaneous push and read issue: ram_cnt is unchanged.
- Output stability: out_data and out_valid hold while out_valid=1 and out_ready=0.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W and ADDR_W defaults.
  - DEPTH = 2**ADDR_W.
  - Output buffer depth constant OBUF_DEPTH = 2.
- One sub-module: fifo_out_buf, the 2-entry register FIFO with capture/pop/count.
- The top-level holds the pointers, ram_cnt, pending, and rd_en logic.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, level=0, ram_wr_a=0, ram_wr_b=0.
- Push 0x11,0x22,0x33 on consecutive cycles with out_ready=0 -> level=3 after third push; out_data=0x11 from edge 3 of first push; order 0x11,0x22,0x33 on pop.
- Fill with 66 words 0x00..0x41 and out_ready=0 -> in_ready drops after ram_cnt=64; level=66; drain returns 0x00..0x41 in order with no loss.
- Continuous push and pop with out_ready=1 for 200 words -> one output per cycle after 3-cycle fill; ram addresses wrap 63->0 correctly.
- Random out_ready (50%) with random in_valid -> scoreboard matches; out_data is stable while stalled.
- Assert rst_n=0 for one cycle with level=10 and a read pending -> the next cycle has level=0 and out_valid=0; a subsequent push of 0xAB emerges as the first output.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared sizing constants for the dual-port-RAM FIFO.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 6;
  localparam int FIFO_DEPTH  = 2**FIFO_ADDR_W;
  localparam int OBUF_DEPTH  = 2;
  localparam int OBUF_CNT_W  = 2;

  typedef logic [OBUF_CNT_W-1:0] obuf_cnt_t;
endpackage
`default_nettype wire

// File: rtl/fifo_out_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_out_buf : 2-entry register FIFO absorbing the RAM read latency. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] cap_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              valid_o,
  output obuf_cnt_t         cnt_o
);
  logic [DATA_W-1:0] ent_q [OBUF_DEPTH];
  logic [DATA_W-1:0] ent_d [OBUF_DEPTH];
  obuf_cnt_t         cnt_q, cnt_d;

  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    cnt_d    = cnt_q;
    case ({cap_i, pop_i})
      2'b10: begin
        if (cnt_q == '0) ent_d[0] = cap_data_i;
        else             ent_d[1] = cap_data_i;
        cnt_d = cnt_q + OBUF_CNT_W'(1);
      end
      2'b01: begin
        ent_d[0] = ent_q[1];
        cnt_d    = cnt_q - OBUF_CNT_W'(1);
      end
      2'b11: begin
        // With one entry held, the captured word replaces the departing head.
        if (cnt_q == OBUF_CNT_W'(1)) begin
          ent_d[0] = cap_data_i;
        end else begin
          ent_d[0] = ent_q[1];
          ent_d[1] = cap_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q    <= '0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = ent_q[0];
  assign valid_o = (cnt_q != '0);
  assign cnt_o   = cnt_q;
endmodule
`default_nettype wire

// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_fifo_ctrl : valid/ready FIFO controller around an external     |
// | dual-port RAM (port A writes, port B reads). Rev 1.0                 |
// +----------------------------------------------------------------------+
module dpram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W+1:0] level,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_wr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_wr_b,
  input  logic [DATA_W-1:0] ram_q_b
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int LVL_W = ADDR_W + 2;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
  logic              pending_q;
  obuf_cnt_t         buf_cnt;
  logic              push, pop, rd_en;
  logic [2:0]        buf_after;

  assign in_ready = (ram_cnt_q != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Issue a read only if the buffer can still hold it once the in-flight word lands.
  assign buf_after = {1'b0, buf_cnt} + {2'b00, pending_q} - {2'b00, pop};
  assign rd_en     = (ram_cnt_q != '0) && (buf_after < 3'd2);

  always_comb begin
    wr_ptr_d  = push  ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    ram_cnt_d = ram_cnt_q + CNT_W'(push) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      pending_q <= rd_en;
    end
  end

  fifo_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_i      (pending_q),
    .cap_data_i (ram_q_b),
    .pop_i      (pop),
    .head_o     (out_data),
    .valid_o    (out_valid),
    .cnt_o      (buf_cnt)
  );

  assign ram_wr_a   = push;
  assign ram_addr_a = wr_ptr_q;
  assign ram_data_a = in_data;
  assign ram_addr_b = rd_ptr_q;
  assign ram_data_b = '0;
  assign ram_wr_b   = 1'b0;

  assign level = LVL_W'(ram_cnt_q) + LVL_W'(pending_q) + LVL_W'(buf_cnt);
endmodule
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dpram_fifo_ctrl : scoreboard bench with a behavioural 64x8 RAM.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dpram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [7:0] level;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_data_a, ram_data_b, ram_q_b;
  logic       ram_wr_a, ram_wr_b;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb_q [$];
  logic [5:0] wp;
  logic       stall_prev;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .ram_wr_a   (ram_wr_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_b (ram_data_b),
    .ram_wr_b   (ram_wr_b),
    .ram_q_b    (ram_q_b)
  );

  // Behavioural 64x8 dual-port RAM with registered read on port B.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_wr_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_wr_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, settle the scoreboard.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r,
                       output logic pushed, output logic popped);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    check("level", level, sb_q.size());
    pushed = in_valid && in_ready;
    check("wr_a", ram_wr_a, pushed);
    if (pushed) begin
      check("addr_a", ram_addr_a, wp);
      check("data_a", ram_data_a, d);
      sb_q.push_back(d);
      wp = wp + 6'd1;
    end
    if (stall_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_data);
    end
    popped = out_valid && out_ready;
    if (popped) begin
      if (sb_q.size() == 0) check("pop_on_empty", 1, 0);
      else                  check("dout", out_data, sb_q.pop_front());
    end
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic drain(input int max_cyc);
    logic p, pp;
    for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1, p, pp);
    check("drain_done", sb_q.size(), 0);
  endtask

  task automatic apply_reset(input int n);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    wp         = 6'd0;
    stall_prev = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic p, pp;
    int   idx, first_pop, gaps, npop;

    wp = 6'd0;
    stall_prev = 1'b0;
    prev_data = 8'h00;
    apply_reset(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_out_data", out_data, 0);
    check("rst_wr_a", ram_wr_a, 0);
    check("rst_wr_b", ram_wr_b, 0);
    check("rst_data_b", ram_data_b, 0);

    // Three pushes, consumer stalled: 3-cycle fall-through.
    cycle(1'b1, 8'h11, 1'b0, p, pp);
    cycle(1'b1, 8'h22, 1'b0, p, pp);
    cycle(1'b1, 8'h33, 1'b0, p, pp);
    check("lat_not_early", out_valid, 0);
    cycle(1'b0, 8'h00, 1'b0, p, pp);
    check("three_level", level, 3);
    check("three_valid", out_valid, 1);
    check("three_head", out_data, 8'h11);
    drain(20);

    // Fill to DEPTH+2 and verify backpressure.
    idx = 0;
    for (int i = 0; i < 200 && idx < 66; i++) begin
      cycle(1'b1, 8'(idx), 1'b0, p, pp);
      if (p) idx++;
    end
    check("fill_count", idx, 66);
    cycle(1'b1, 8'hEE, 1'b0, p, pp);
    check("full_ready", in_ready, 0);
    check("full_level", level, 66);
    drain(200);

    // Streaming: one word per cycle after the fill latency.
    first_pop = -1; gaps = 0; npop = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 8'(i * 3 + 1), 1'b1, p, pp);
      if (pp) begin
        if (first_pop < 0) first_pop = i;
        npop++;
      end else if (first_pop >= 0) gaps++;
    end
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      cycle(1'b0, 8'h00, 1'b1, p, pp);
      if (pp) npop++;
      else    gaps++;
    end
    check("stream_first", first_pop, 3);
    check("stream_gaps", gaps, 0);
    check("stream_count", npop, 200);

    // Random traffic on both sides.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), p, pp);
    drain(300);

    // Mid-stream reset with level 10 and a read in flight.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, p, pp);
    for (int i = 0; i < 3; i++)  cycle(1'b0, 8'h00, 1'b0, p, pp);
    cycle(1'b1, 8'hAA, 1'b1, p, pp);
    cycle(1'b0, 8'h00, 1'b0, p, pp);
    check("pre_rst_level", level, 10);
    apply_reset(1);
    check("post_rst_level", level, 0);
    check("post_rst_valid", out_valid, 0);
    cycle(1'b1, 8'hAB, 1'b0, p, pp);
    for (int i = 0; i < 10 && !out_valid; i++) cycle(1'b0, 8'h00, 1'b0, p, pp);
    check("post_rst_head", out_data, 8'hAB);
    drain(10);
    cycle(1'b0, 8'h00, 1'b0, p, pp);
    check("final_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
